// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/bubble_cnt performance counters.
module pipe_stage_reg #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 165,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Encoding is {main valid, skid valid}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } stateT;

  stateT state_q, state_d;

  logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d, skidCtrl_q, skidCtrl_d;
  logic [DATA_W-1:0] mainData_q, mainData_d, skidData_q, skidData_d;
  logic              acc, drn;
  logic              loadMainIn, loadMainSkid, loadSkid;

  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Flush squashes both entries and discards any concurrent accept.
  always_comb begin
    state_d      = state_q;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d    = ONE;
            loadMainIn = 1'b1;
          end
        end
        ONE: begin
          if (acc && drn) begin
            loadMainIn = 1'b1;
          end else if (drn) begin
            state_d = EMPTY;
          end else if (acc) begin
            state_d  = FULL;
            loadSkid = 1'b1;
          end
        end
        FULL: begin
          if (drn) begin
            state_d      = ONE;
            loadMainSkid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = state_q[1];
    out_ctrl  = state_q[1] ? mainCtrl_q : '0;
    out_data  = mainData_q;
  end

  always_comb begin
    mainCtrl_d = mainCtrl_q;
    mainData_d = mainData_q;
    skidCtrl_d = skidCtrl_q;
    skidData_d = skidData_q;
    if (loadMainIn) begin
      mainCtrl_d = in_ctrl;
      mainData_d = in_data;
    end else if (loadMainSkid) begin
      mainCtrl_d = skidCtrl_q;
      mainData_d = skidData_q;
    end
    if (loadSkid) begin
      skidCtrl_d = in_ctrl;
      skidData_d = in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mainCtrl_q <= '0;
      mainData_q <= '0;
      skidCtrl_q <= '0;
      skidData_q <= '0;
    end else begin
      mainCtrl_q <= mainCtrl_d;
      mainData_q <= mainData_d;
      skidCtrl_q <= skidCtrl_d;
      skidData_q <= skidData_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stallCnt_q, bubbleCnt_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
    end else begin
      if (out_valid && !out_ready) stallCnt_q <= stallCnt_q + CNT_W'(1);
      if (!out_valid)              bubbleCnt_q <= bubbleCnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stallCnt_q;
  assign bubble_cnt = bubbleCnt_q;
`else
  logic [CNT_W-1:0] perfUnused;
  assign perfUnused = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table, FIFO-order scoreboard run, optional counter check.
module tb_pipe_stage_reg;

  logic         clock = 1'b0;
  logic         reset, flush, inValid, inReady, outValid, outReady;
  logic [15:0]  inCtrl, outCtrl;
  logic [164:0] inData, outData;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  stallCnt, bubbleCnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_stage_reg dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_ctrl   (inCtrl),
    .in_data   (inData),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_ctrl  (outCtrl),
    .out_data  (outData)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stallCnt),
    .bubble_cnt(bubbleCnt)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic        rst, fl, iv;
    logic [15:0] ictrl;
    logic [31:0] idata;
    logic        ordy;
    logic        eRdy, eVld;
    logic [15:0] eCtrl;
    logic [31:0] eData;
    logic        chkData;
  } vecT;

  vecT vecs[27];

  function automatic vecT mk(logic rst, logic fl, logic iv, logic [15:0] ictrl, logic [31:0] idata,
                             logic ordy, logic eRdy, logic eVld, logic [15:0] eCtrl,
                             logic [31:0] eData, logic chkData);
    vecT v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ictrl = ictrl; v.idata = idata; v.ordy = ordy;
    v.eRdy = eRdy; v.eVld = eVld; v.eCtrl = eCtrl; v.eData = eData; v.chkData = chkData;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vecT v);
    reset    = v.rst;
    flush    = v.fl;
    inValid  = v.iv;
    inCtrl   = v.ictrl;
    inData   = 165'(v.idata);
    outReady = v.ordy;
    tick();
  endtask

  int expQ[$];
  int sent, recv;

  initial begin
    reset = 1'b1; flush = 1'b0; inValid = 1'b0; inCtrl = '0; inData = '0; outReady = 1'b0;

    // Expected values describe the outputs just after the edge the row's inputs were applied at.
    vecs[0] = mk(1, 0, 1, 16'hFFFF, 32'h99, 0,  1, 0, 16'h0, 32'h0, 1);
    vecs[1] = mk(0, 0, 0, 16'hFFFF, 32'h0,  1,  1, 0, 16'h0, 32'h0, 1);
    for (int i = 1; i <= 8; i++)
      vecs[1+i] = mk(0, 0, 1, 16'(16'h100 + i), 32'(i), 1,  1, 1, 16'(16'h100 + i), 32'(i), 1);
    vecs[10] = mk(0, 0, 0, 16'hFFFF, 32'h0,  1,  1, 0, 16'h0, 32'h8,  1);
    vecs[11] = mk(0, 0, 1, 16'h000A, 32'h11, 0,  1, 1, 16'hA, 32'h11, 1);
    vecs[12] = mk(0, 0, 1, 16'h000B, 32'h22, 0,  0, 1, 16'hA, 32'h11, 1);
    vecs[13] = mk(0, 0, 1, 16'h000C, 32'h33, 0,  0, 1, 16'hA, 32'h11, 1);
    vecs[14] = mk(0, 0, 0, 16'h0,    32'h0,  1,  1, 1, 16'hB, 32'h22, 1);
    vecs[15] = mk(0, 0, 0, 16'h0,    32'h0,  1,  1, 0, 16'h0, 32'h22, 1);
    vecs[16] = mk(0, 0, 1, 16'h000A, 32'h11, 0,  1, 1, 16'hA, 32'h11, 1);
    vecs[17] = mk(0, 0, 1, 16'h000B, 32'h22, 0,  0, 1, 16'hA, 32'h11, 1);
    vecs[18] = mk(0, 1, 1, 16'h000C, 32'h33, 0,  1, 0, 16'h0, 32'h0,  0);
    vecs[19] = mk(0, 0, 0, 16'h0,    32'h0,  1,  1, 0, 16'h0, 32'h0,  0);
    vecs[20] = mk(0, 0, 0, 16'h0,    32'h0,  1,  1, 0, 16'h0, 32'h0,  0);
    vecs[21] = mk(0, 1, 1, 16'h000D, 32'h44, 1,  1, 0, 16'h0, 32'h0,  0);
    vecs[22] = mk(0, 0, 0, 16'hFFFF, 32'h0,  1,  1, 0, 16'h0, 32'h0,  0);
    vecs[23] = mk(0, 0, 1, 16'h000A, 32'h11, 0,  1, 1, 16'hA, 32'h11, 1);
    vecs[24] = mk(0, 0, 1, 16'h000B, 32'h22, 0,  0, 1, 16'hA, 32'h11, 1);
    vecs[25] = mk(1, 0, 1, 16'h000C, 32'h33, 0,  1, 0, 16'h0, 32'h0,  1);
    vecs[26] = mk(0, 0, 0, 16'h0,    32'h0,  1,  1, 0, 16'h0, 32'h0,  1);

    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_in_ready", i),  192'(inReady),  192'(vecs[i].eRdy));
      checkOutput($sformatf("v%0d_out_valid", i), 192'(outValid), 192'(vecs[i].eVld));
      checkOutput($sformatf("v%0d_out_ctrl", i),  192'(outCtrl),  192'(vecs[i].eCtrl));
      if (vecs[i].chkData)
        checkOutput($sformatf("v%0d_out_data", i), 192'(outData), 192'(vecs[i].eData));
    end

    // Ordering under irregular backpressure: 20 entries must emerge in order, nothing lost.
    reset = 1'b0; flush = 1'b0;
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 300 && recv < 20; cyc++) begin
      inValid  = (sent < 20);
      inCtrl   = 16'(sent);
      inData   = 165'(200 + sent);
      outReady = ((cyc % 3) != 0) && ((cyc % 7) != 5);
      if (outValid && outReady) begin
        if (expQ.size() > 0) begin
          checkOutput("fifo_data", 192'(outData), 192'(expQ[0] + 200));
          checkOutput("fifo_ctrl", 192'(outCtrl), 192'(expQ[0]));
          void'(expQ.pop_front());
        end else begin
          checkOutput("fifo_spurious_valid", 192'(outValid), 192'(0));
        end
        recv++;
      end
      if (inValid && inReady) begin
        expQ.push_back(sent);
        sent++;
      end
      tick();
    end
    checkOutput("fifo_recv_count", 192'(recv), 192'(20));
    inValid = 1'b0; outReady = 1'b1;
    tick();
    checkOutput("fifo_empty_after", 192'(outValid), 192'(0));

`ifdef PIPE_STAGE_PERF_EN
    // One bubble while loading, five stalled cycles, one drain, then three empty cycles.
    reset = 1'b1; inValid = 1'b0; outReady = 1'b0;
    tick();
    checkOutput("perf_reset_stall", 192'(stallCnt), 192'(0));
    checkOutput("perf_reset_bubble", 192'(bubbleCnt), 192'(0));
    reset = 1'b0; inValid = 1'b1; inCtrl = 16'h5; inData = 165'h55;
    tick();
    inValid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    outReady = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    checkOutput("perf_stall", 192'(stallCnt), 192'(5));
    checkOutput("perf_bubble", 192'(bubbleCnt), 192'(4));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("perf_clear_stall", 192'(stallCnt), 192'(0));
    checkOutput("perf_clear_bubble", 192'(bubbleCnt), 192'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
